// File: rtl/mdu_pkg.sv
// Shared constants and types for the MIPS multiply/divide unit.
// Op encodings match the 2-bit op field driven by the control unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_addsub.sv
// Shared add/subtract for the mult/div engine.
// co_o is carry on add, and "no borrow" on subtract.
module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] res_o,
  output logic         co_o
);

  logic [W:0] sum;

  assign sum = {1'b0, x_i}
             + {1'b0, y_i ^ {W{sub_i}}}
             + {{W{1'b0}}, sub_i};

  assign {co_o, res_o} = sum;

endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Operates on magnitudes; signs are applied in the FIX state.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             negl_q, negl_d;
  logic             negh_q, negh_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign sgn   = ~op[0];
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_abs = a_neg ? ('0 - a) : a;
  assign b_abs = b_neg ? ('0 - b) : b;

  // Mult adds into the high half; div shifts the next dividend bit in.
  logic [WIDTH:0] as_x, as_y, as_r, step;
  logic           as_co;

  assign as_x = div_q ? {acc_q, shr_q[WIDTH-1]}
                      : {1'b0, acc_q};
  assign as_y = {1'b0, b_q};

  mdu_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .x_i  (as_x),
    .y_i  (as_y),
    .sub_i(div_q),
    .res_o(as_r),
    .co_o (as_co)
  );

  assign step = shr_q[0] ? as_r : as_x;

  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH-1:0]   quot, rem;

  assign prod   = {acc_q, shr_q};
  assign prod_n = negl_q ? ('0 - prod) : prod;
  assign quot   = negl_q ? ('0 - shr_q) : shr_q;
  assign rem    = negh_q ? ('0 - acc_q) : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    negl_d  = negl_q;
    negh_d  = negh_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    b_d     = b_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          state_d = S_CALC;
          cnt_d   = '0;
          div_d   = op[1];
          a_d     = a;
          acc_d   = '0;
          negl_d  = a_neg ^ b_neg;
          dz_d    = op[1] & (b == '0);
          if (op[1]) begin
            b_d    = b_abs;
            shr_d  = a_abs;
            negh_d = a_neg;
          end else begin
            b_d    = a_abs;
            shr_d  = b_abs;
            negh_d = a_neg ^ b_neg;
          end
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (div_q) begin
            acc_d = as_co ? as_r[WIDTH-1:0]
                          : as_x[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], as_co};
          end else begin
            acc_d = step[WIDTH:1];
            shr_d = {step[0], shr_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else if (div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            {hi_d, lo_d} = prod_n;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      negl_q  <= 1'b0;
      negh_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      shr_q   <= '0;
      b_q     <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      negl_q  <= negl_d;
      negh_q  <= negh_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      b_q     <= b_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops
// checked against plain 64-bit arithmetic.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cancel(cancel),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from the architectural definition.
  function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ix = int'(x);
    iy = int'(y);
    case (o)
      MDU_MULT:  return 64'(sx * sy);
      MDU_MULTU: return {32'b0, x} * {32'b0, y};
      MDU_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'h0, x};
        return {32'(ix % iy), 32'(ix / iy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called #1 after an edge; leaves #1 after the sampling edge.
  task automatic launch(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // n0 = edges already elapsed since the sampling edge.
  task automatic wait_done(input string tag,
                           input logic [1:0] o,
                           input logic [31:0] x,
                           input logic [31:0] y,
                           input int n0);
    int n;
    logic [63:0] r;
    n = n0;
    r = ref_op(o, x, y);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd33);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_hi"}, hi, r[63:32]);
    chk({tag, "_lo"}, lo, r[31:0]);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(posedge clk); #1;
    launch(o, x, y);
    chk1({tag, "_start"}, busy, 1'b1);
    wait_done(tag, o, x, y, 0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int seen;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // Reset mid-CALC clears everything, including an MTHI value.
    @(posedge clk); #1;
    hi_we = 1'b1;
    wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi0", hi, 32'hCAFE_0001);
    launch(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk1("rmid_busy", busy, 1'b0);
    chk1("rmid_done", done, 1'b0);
    chk("rmid_hi", hi, 32'h0);
    chk("rmid_lo", lo, 32'h0);
    exp_hi = '0;
    exp_lo = '0;
    do_op("after_rst", MDU_MULTU, 32'd1000, 32'd3000);

    do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk1("done_1cyc", done, 1'b0);
    do_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    do_op("mult_min", MDU_MULT, 32'h8000_0000, 32'h8000_0000);
    do_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_z", MDU_DIVU, 32'd7, 32'd0);
    do_op("div_z", MDU_DIV, 32'hFFFF_FF00, 32'd0);
    do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start while busy is ignored; start in the done cycle is taken.
    @(posedge clk); #1;
    launch(MDU_MULTU, 32'h0000_FFFF, 32'h0001_0001);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = MDU_DIV;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", MDU_MULTU, 32'h0000_FFFF, 32'h0001_0001, 5);
    launch(MDU_DIVU, 32'd1000, 32'd7);
    chk1("b2b_busy", busy, 1'b1);
    chk1("b2b_done", done, 1'b0);
    wait_done("b2b", MDU_DIVU, 32'd1000, 32'd7, 0);

    // Cancel together with start in IDLE drops the start.
    @(posedge clk); #1;
    start  = 1'b1;
    cancel = 1'b1;
    op     = MDU_MULTU;
    @(posedge clk); #1;
    start  = 1'b0;
    cancel = 1'b0;
    chk1("cstart_busy", busy, 1'b0);

    // MT write alongside an accepted start; result overwrites later.
    @(posedge clk); #1;
    lo_we = 1'b1;
    wdata = 32'h5555_AAAA;
    launch(MDU_MULTU, 32'd3, 32'd4);
    lo_we = 1'b0;
    chk("mtst_lo", lo, 32'h5555_AAAA);
    chk1("mtst_busy", busy, 1'b1);
    wait_done("mtst", MDU_MULTU, 32'd3, 32'd4, 0);

    // MTHI, then a cancelled DIVU with an ignored MTLO while busy.
    @(posedge clk); #1;
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    exp_hi = 32'h0000_1234;
    launch(MDU_DIVU, 32'd9, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo_busy", lo, exp_lo);
    repeat (4) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk1("cancel_busy", busy, 1'b0);
    chk("cancel_hi", hi, exp_hi);
    chk("cancel_lo", lo, exp_lo);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("cancel_nodone", 32'(seen), 32'd0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      if (i % 5 == 0) ry = '0;
      else if (i % 3 == 0) ry = $urandom_range(1, 15);
      do_op("rnd", ro, rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
